vector_ldst_arbiter: RTL and testbench

- Sits directly downstream of the vector unit's per-lane load/store request outputs.
- Arbitrates the NUM_LANES lane requests onto the single memory access port, one burst at a time, using round-robin priority.
- Returns per-lane grant, per-beat ready and end-of-access pulses to the lanes.
- Routes store data from the granted lane to memory and broadcasts load data to all lanes.

---
 rtl/vector_ldst_arbiter_if.sv | 28 ++
 rtl/vector_ldst_arbiter.sv | 144 ++++++++++++++
 tb/tb_vector_ldst_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_ldst_arbiter_if.sv
// Memory-side access port of the vector load/store arbiter.
// One burst request, ack, per-beat strobe and load/store data.
interface vector_ldst_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  O_Mem_Req;
  logic                  O_Mem_St;
  logic [ADDR_WIDTH-1:0] O_Mem_Addr;
  logic [LEN_WIDTH-1:0]  O_Mem_Len;
  logic [DATA_WIDTH-1:0] O_Mem_St_Data;
  logic                  I_Mem_Ack;
  logic                  I_Mem_Beat;
  logic [DATA_WIDTH-1:0] I_Mem_Ld_Data;

  modport master (
    output O_Mem_Req, O_Mem_St, O_Mem_Addr,
    output O_Mem_Len, O_Mem_St_Data,
    input  I_Mem_Ack, I_Mem_Beat, I_Mem_Ld_Data
  );

  modport slave (
    input  O_Mem_Req, O_Mem_St, O_Mem_Addr,
    input  O_Mem_Len, O_Mem_St_Data,
    output I_Mem_Ack, I_Mem_Beat, I_Mem_Ld_Data
  );
endinterface

// File: rtl/vector_ldst_arbiter.sv
// Round-robin arbiter of vector lane load/store bursts
// onto a single memory access port.
module vector_ldst_arbiter #(
  parameter int NUM_LANES  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_LANES-1:0]            I_Req,
  input  logic [NUM_LANES-1:0]            I_St,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0] I_Addr,
  input  logic [NUM_LANES*LEN_WIDTH-1:0]  I_Len,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] I_St_Data,
  output logic [NUM_LANES-1:0]            O_Grant,
  output logic [NUM_LANES-1:0]            O_Ready,
  output logic [NUM_LANES-1:0]            O_End_Access,
  output logic [DATA_WIDTH-1:0]           O_Ld_Data,
  vector_ldst_arbiter_if.master           mem
);

  localparam int IW = $clog2(NUM_LANES);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;
  localparam logic [NUM_LANES-1:0] GNT_ONE = 1;

  typedef enum logic [1:0] {
    IDLE, REQ, XFER, END
  } state_t;

  state_t state, state_n;

  logic [IW-1:0]         rr;
  logic [IW-1:0]         g_idx;
  logic [IW-1:0]         sel_idx;
  logic                  found;
  int                    k;
  logic [NUM_LANES-1:0]  gnt;
  logic                  b_st;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [LEN_WIDTH-1:0]  b_len;
  logic [LEN_WIDTH-1:0]  cnt;
  logic                  latch;
  logic                  cnt_clr;
  logic                  cnt_inc;
  logic                  rr_adv;

  // First requester at or after rr, wrapping around.
  always_comb begin
    sel_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      k = (int'(rr) + i) % NUM_LANES;
      if (!found && I_Req[k]) begin
        found   = 1'b1;
        sel_idx = IW'(k);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    latch   = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    rr_adv  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|I_Req) begin
          latch   = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (b_len == '0) begin
          state_n = END;
        end else if (mem.I_Mem_Ack) begin
          cnt_clr = 1'b1;
          state_n = XFER;
        end
      end
      XFER: begin
        if (mem.I_Mem_Beat) begin
          cnt_inc = 1'b1;
          if (cnt + LEN_ONE == b_len)
            state_n = END;
        end
      end
      END: begin
        rr_adv  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr     <= '0;
      g_idx  <= '0;
      gnt    <= '0;
      b_st   <= 1'b0;
      b_addr <= '0;
      b_len  <= '0;
      cnt    <= '0;
    end else begin
      if (latch) begin
        g_idx  <= sel_idx;
        gnt    <= GNT_ONE << sel_idx;
        b_st   <= I_St[sel_idx];
        b_addr <= I_Addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
        b_len  <= I_Len[sel_idx*LEN_WIDTH +: LEN_WIDTH];
      end
      if (cnt_clr) cnt <= '0;
      else if (cnt_inc) cnt <= cnt + LEN_ONE;
      if (rr_adv) begin
        gnt <= '0;
        rr  <= (g_idx == IW'(NUM_LANES - 1)) ? '0
             : g_idx + IW'(1);
      end
    end
  end

  assign O_Grant      = gnt;
  assign O_Ready      = (state == XFER && mem.I_Mem_Beat)
                        ? gnt : '0;
  assign O_End_Access = (state == END) ? gnt : '0;
  assign O_Ld_Data    = (|gnt) ? mem.I_Mem_Ld_Data : '0;

  // A zero-length burst never touches memory.
  assign mem.O_Mem_Req  = (state == REQ) && (b_len != '0);
  assign mem.O_Mem_St   = b_st;
  assign mem.O_Mem_Addr = b_addr;
  assign mem.O_Mem_Len  = b_len;
  assign mem.O_Mem_St_Data = (|gnt)
    ? I_St_Data[g_idx*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_vector_ldst_arbiter.sv
// Directed bench for vector_ldst_arbiter.
// Linear sequence of steps with hand-computed expectations.
module tb_vector_ldst_arbiter;

  localparam int NL = 4;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int DW = 32;

  logic              clock;
  logic              reset;
  logic [NL-1:0]     I_Req;
  logic [NL-1:0]     I_St;
  logic [NL*AW-1:0]  I_Addr;
  logic [NL*LW-1:0]  I_Len;
  logic [NL*DW-1:0]  I_St_Data;
  logic [NL-1:0]     O_Grant;
  logic [NL-1:0]     O_Ready;
  logic [NL-1:0]     O_End_Access;
  logic [DW-1:0]     O_Ld_Data;

  int vectors;
  int miscompares;

  vector_ldst_arbiter_if #(
    .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)
  ) mem_bus ();

  vector_ldst_arbiter #(
    .NUM_LANES(NL), .ADDR_WIDTH(AW),
    .LEN_WIDTH(LW), .DATA_WIDTH(DW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .I_Req(I_Req),
    .I_St(I_St),
    .I_Addr(I_Addr),
    .I_Len(I_Len),
    .I_St_Data(I_St_Data),
    .O_Grant(O_Grant),
    .O_Ready(O_Ready),
    .O_End_Access(O_End_Access),
    .O_Ld_Data(O_Ld_Data),
    .mem(mem_bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int l, input logic st,
                          input logic [AW-1:0] addr,
                          input logic [LW-1:0] len);
    I_St[l] = st;
    I_Addr[l*AW +: AW] = addr;
    I_Len[l*LW +: LW] = len;
  endtask

  logic [NL-1:0] rr_exp [6];

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset     = 1'b0;
    I_Req     = '0;
    I_St      = '0;
    I_Addr    = '0;
    I_Len     = '0;
    I_St_Data = '0;
    mem_bus.I_Mem_Ack     = 1'b0;
    mem_bus.I_Mem_Beat    = 1'b0;
    mem_bus.I_Mem_Ld_Data = 32'h5555_AAAA;

    // reset state
    tick(); tick();
    chk("rst_grant", 64'(O_Grant), 64'h0);
    chk("rst_memreq", 64'(mem_bus.O_Mem_Req), 64'h0);
    chk("rst_end", 64'(O_End_Access), 64'h0);
    chk("rst_ld", 64'(O_Ld_Data), 64'h0);
    chk("rst_addr", 64'(mem_bus.O_Mem_Addr), 64'h0);
    reset = 1'b1;
    tick();

    // round robin: lanes 0,1,3, Len=1 each
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b1000; rr_exp[3] = 4'b0001;
    rr_exp[4] = 4'b0010; rr_exp[5] = 4'b1000;
    for (int l = 0; l < NL; l++)
      set_lane(l, 1'b0, 32'h40 * l, 8'd1);
    I_Req = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr_grant%0d", i),
          64'(O_Grant), 64'(rr_exp[i]));
      mem_bus.I_Mem_Ack = 1'b1;
      tick();
      mem_bus.I_Mem_Ack  = 1'b0;
      mem_bus.I_Mem_Beat = 1'b1;
      tick();
      mem_bus.I_Mem_Beat = 1'b0;
      #1;
      chk($sformatf("rr_end%0d", i),
          64'(O_End_Access), 64'(rr_exp[i]));
      tick();
    end
    I_Req = '0;
    tick();
    chk("idle_ld_zero", 64'(O_Ld_Data), 64'h0);

    // single load on lane 2
    set_lane(2, 1'b0, 32'h100, 8'd3);
    I_Req = 4'b0100;
    tick();
    chk("ld_grant", 64'(O_Grant), 64'h4);
    chk("ld_memreq", 64'(mem_bus.O_Mem_Req), 64'h1);
    chk("ld_addr", 64'(mem_bus.O_Mem_Addr), 64'h100);
    chk("ld_len", 64'(mem_bus.O_Mem_Len), 64'h3);
    chk("ld_st", 64'(mem_bus.O_Mem_St), 64'h0);
    I_Req = '0;
    mem_bus.I_Mem_Ack  = 1'b1;
    mem_bus.I_Mem_Beat = 1'b1;
    #1;
    chk("ld_req_beat_ign", 64'(O_Ready), 64'h0);
    tick();
    chk("ld_memreq_drop", 64'(mem_bus.O_Mem_Req), 64'h0);
    mem_bus.I_Mem_Ack = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_bus.I_Mem_Beat    = 1'b1;
      mem_bus.I_Mem_Ld_Data = 32'hA0 + b;
      #1;
      chk($sformatf("ld_ready%0d", b),
          64'(O_Ready), 64'h4);
      chk($sformatf("ld_data%0d", b),
          64'(O_Ld_Data), 64'(32'hA0 + b));
      chk($sformatf("ld_noend%0d", b),
          64'(O_End_Access), 64'h0);
      tick();
    end
    mem_bus.I_Mem_Beat = 1'b0;
    #1;
    chk("ld_end", 64'(O_End_Access), 64'h4);
    chk("ld_end_grant", 64'(O_Grant), 64'h4);
    chk("ld_end_ready", 64'(O_Ready), 64'h0);
    tick();
    chk("ld_after_grant", 64'(O_Grant), 64'h0);
    chk("ld_after_end", 64'(O_End_Access), 64'h0);

    // RR=3: lanes 0 and 3 both ask, lane 3 wins
    set_lane(3, 1'b0, 32'h300, 8'd0);
    set_lane(0, 1'b0, 32'h000, 8'd0);
    I_Req = 4'b1001;
    tick();
    chk("rr3_grant", 64'(O_Grant), 64'h8);
    I_Req = '0;
    tick();
    chk("rr3_end", 64'(O_End_Access), 64'h8);
    tick();

    // Len=0 on lane 0
    I_Req = 4'b0001;
    tick();
    chk("z_grant", 64'(O_Grant), 64'h1);
    chk("z_memreq_a", 64'(mem_bus.O_Mem_Req), 64'h0);
    I_Req = '0;
    tick();
    chk("z_end", 64'(O_End_Access), 64'h1);
    chk("z_memreq_b", 64'(mem_bus.O_Mem_Req), 64'h0);
    tick();
    chk("z_after_end", 64'(O_End_Access), 64'h0);

    // store routing on lane 1
    set_lane(1, 1'b1, 32'h200, 8'd2);
    I_St_Data = {32'h3333_3333, 32'h2222_2222,
                 32'hDEAD_BEEF, 32'h1111_1111};
    I_Req = 4'b0010;
    tick();
    chk("st_memst", 64'(mem_bus.O_Mem_St), 64'h1);
    chk("st_data_req", 64'(mem_bus.O_Mem_St_Data),
        64'hDEADBEEF);
    I_Req = '0;
    mem_bus.I_Mem_Ack = 1'b1;
    I_St_Data[0*DW +: DW] = 32'h0BAD_0000;
    I_St_Data[2*DW +: DW] = 32'h0BAD_0002;
    tick();
    mem_bus.I_Mem_Ack  = 1'b0;
    mem_bus.I_Mem_Beat = 1'b1;
    #1;
    chk("st_ready0", 64'(O_Ready), 64'h2);
    chk("st_data_b0", 64'(mem_bus.O_Mem_St_Data),
        64'hDEADBEEF);
    tick();
    I_St_Data[3*DW +: DW] = 32'h0BAD_0003;
    #1;
    chk("st_data_b1", 64'(mem_bus.O_Mem_St_Data),
        64'hDEADBEEF);
    tick();
    mem_bus.I_Mem_Beat = 1'b0;
    #1;
    chk("st_end", 64'(O_End_Access), 64'h2);
    chk("st_data_end", 64'(mem_bus.O_Mem_St_Data),
        64'hDEADBEEF);
    tick();
    chk("st_data_idle", 64'(mem_bus.O_Mem_St_Data), 64'h0);

    // reset mid-burst, lane 3 Len=4 with RR=2
    set_lane(3, 1'b0, 32'h380, 8'd4);
    I_Req = 4'b1000;
    tick();
    chk("rm_grant", 64'(O_Grant), 64'h8);
    I_Req = '0;
    mem_bus.I_Mem_Ack = 1'b1;
    tick();
    mem_bus.I_Mem_Ack  = 1'b0;
    mem_bus.I_Mem_Beat = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rm_grant0", 64'(O_Grant), 64'h0);
    chk("rm_ready0", 64'(O_Ready), 64'h0);
    chk("rm_end0", 64'(O_End_Access), 64'h0);
    chk("rm_stdata0", 64'(mem_bus.O_Mem_St_Data), 64'h0);
    chk("rm_ld0", 64'(O_Ld_Data), 64'h0);
    mem_bus.I_Mem_Beat = 1'b0;
    tick();
    chk("rm_noend", 64'(O_End_Access), 64'h0);
    set_lane(1, 1'b0, 32'h210, 8'd0);
    I_Req = 4'b1010;
    reset = 1'b1;
    tick();
    chk("rm_rr_grant", 64'(O_Grant), 64'h2);
    I_Req = '0;
    tick();
    chk("rm_rr_end", 64'(O_End_Access), 64'h2);
    tick();

    // lane 3 drops Req after beat 1 of Len=4
    set_lane(3, 1'b0, 32'h3C0, 8'd4);
    I_Req = 4'b1000;
    tick();
    chk("rd_grant", 64'(O_Grant), 64'h8);
    chk("rd_len", 64'(mem_bus.O_Mem_Len), 64'h4);
    mem_bus.I_Mem_Ack = 1'b1;
    tick();
    mem_bus.I_Mem_Ack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_bus.I_Mem_Beat = 1'b1;
      #1;
      chk($sformatf("rd_ready%0d", b),
          64'(O_Ready), 64'h8);
      tick();
      if (b == 0) begin
        I_Req = '0;
        set_lane(3, 1'b0, 32'hFFF0, 8'd1);
      end
    end
    mem_bus.I_Mem_Beat = 1'b0;
    #1;
    chk("rd_end", 64'(O_End_Access), 64'h8);
    chk("rd_addr_held", 64'(mem_bus.O_Mem_Addr), 64'h3C0);
    tick();
    chk("rd_after_grant", 64'(O_Grant), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
